// File: rtl/lsu_bus_clken_gen_pkg.sv
`default_nettype none
// ============================================================================
// lsu_bus_clken_gen_pkg : shared types for the LSU bus clock-enable generator
// Rev 1.0 - initial release
// ============================================================================
package lsu_bus_clken_gen_pkg;

    localparam int unsigned RATIO_W = 4;

    typedef enum logic [1:0] {
        BCK_RUN    = 2'd0,
        BCK_DRAIN  = 2'd1,
        BCK_SWITCH = 2'd2
    } bus_clken_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_bus_clken_gen.sv
`default_nettype none
// ============================================================================
// lsu_bus_clken_gen : one-cycle bus clock enable every (ratio_cur+1) core clocks
// with quiesce/drain ratio switching. Optional: RV_BUS_CLKEN_PREDICT_EN.
// Rev 1.0 - initial release
// ============================================================================
module lsu_bus_clken_gen
    import lsu_bus_clken_gen_pkg::*;
#(
    parameter logic [RATIO_W-1:0] RESET_RATIO = 4'h0
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               ratio_req_vld,
    input  logic [RATIO_W-1:0] ratio_req,
    input  logic               lsu_bus_buffer_empty_any,
    input  logic               lsu_stbuf_empty_any,
    output logic               lsu_bus_clk_en,
    output logic               lsu_bus_clk_en_nxt,
    output logic               lsu_bus_quiesce,
    output logic               ratio_req_ack,
    output logic [RATIO_W-1:0] ratio_cur
);

    bus_clken_state_t   state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] ratio_cur_q, ratio_cur_d;
    logic [RATIO_W-1:0] ratio_pend_q, ratio_pend_d;
    logic               ack_q, ack_d;
    logic               boundary;

    assign boundary = (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = boundary ? ratio_cur_q : (cnt_q - 4'd1);
        ratio_cur_d  = ratio_cur_q;
        ratio_pend_d = ratio_pend_q;
        ack_d        = 1'b0;

        case (state_q)
            BCK_RUN: begin
                if (ratio_req_vld) begin
                    if (ratio_req != ratio_cur_q) begin
                        ratio_pend_d = ratio_req;
                        state_d      = BCK_DRAIN;
                    end else if (!ack_q) begin
                        // a request still held high in its ack cycle must not ack twice
                        ack_d = 1'b1;
                    end
                end
            end
            BCK_DRAIN: begin
                if (lsu_bus_buffer_empty_any && lsu_stbuf_empty_any && boundary) begin
                    state_d = BCK_SWITCH;
                    cnt_d   = '0;
                end
            end
            BCK_SWITCH: begin
                ratio_cur_d = ratio_pend_q;
                cnt_d       = ratio_pend_q;
                state_d     = BCK_RUN;
            end
            default: begin
                state_d = BCK_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= BCK_RUN;
            cnt_q        <= '0;
            ratio_cur_q  <= RESET_RATIO;
            ratio_pend_q <= '0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ratio_cur_q  <= ratio_cur_d;
            ratio_pend_q <= ratio_pend_d;
            ack_q        <= ack_d;
        end
    end

    assign lsu_bus_clk_en  = boundary;
    assign lsu_bus_quiesce = (state_q != BCK_RUN);
    assign ratio_req_ack   = ack_q | (state_q == BCK_SWITCH);
    assign ratio_cur       = ratio_cur_q;

`ifdef RV_BUS_CLKEN_PREDICT_EN
    // next counter value already folds in the drain-exit clear and the switch reload
    assign lsu_bus_clk_en_nxt = (cnt_d == '0);
`else
    assign lsu_bus_clk_en_nxt = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_clken_gen.sv
`default_nettype none
// ============================================================================
// tb_lsu_bus_clken_gen : randomized scoreboard bench for lsu_bus_clken_gen
// Rev 1.0 - initial release
// ============================================================================
module tb_lsu_bus_clken_gen;

    localparam logic [3:0] RESET_RATIO = 4'h0;
    localparam int MODE_IDLE = 0;
    localparam int MODE_DRAIN = 1;
    localparam int MODE_SWITCH = 2;

    logic       clk;
    logic       rst_l;
    logic       ratio_req_vld;
    logic [3:0] ratio_req;
    logic       bb_empty;
    logic       sb_empty;
    logic       lsu_bus_clk_en;
    logic       lsu_bus_clk_en_nxt;
    logic       lsu_bus_quiesce;
    logic       ratio_req_ack;
    logic [3:0] ratio_cur;

    int errors = 0;
    int checks = 0;

    lsu_bus_clken_gen #(.RESET_RATIO(RESET_RATIO)) u_dut (
        .clk                      (clk),
        .rst_l                    (rst_l),
        .ratio_req_vld            (ratio_req_vld),
        .ratio_req                (ratio_req),
        .lsu_bus_buffer_empty_any (bb_empty),
        .lsu_stbuf_empty_any      (sb_empty),
        .lsu_bus_clk_en           (lsu_bus_clk_en),
        .lsu_bus_clk_en_nxt       (lsu_bus_clk_en_nxt),
        .lsu_bus_quiesce          (lsu_bus_quiesce),
        .ratio_req_ack            (ratio_req_ack),
        .ratio_cur                (ratio_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: pulse timeline + request lifecycle ----
    logic [3:0] sb_q[$];
    int         cyc = 0;
    int         m_next = 0;
    int         m_mode = MODE_IDLE;
    logic [3:0] m_cur = RESET_RATIO;
    logic [3:0] m_pend = 4'h0;
    logic       m_ack_next = 1'b0;
    logic       prev_nxt = 1'b0;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        logic exp_pulse;
        logic exp_ack;
        cyc++;
        if (!rst_l) begin
            ck("reset_clk_en", {31'd0, lsu_bus_clk_en}, 32'd1);
            ck("reset_quiesce", {31'd0, lsu_bus_quiesce}, 32'd0);
            ck("reset_ack", {31'd0, ratio_req_ack}, 32'd0);
            ck("reset_ratio_cur", {28'd0, ratio_cur}, {28'd0, RESET_RATIO});
`ifdef RV_BUS_CLKEN_PREDICT_EN
            ck("reset_clk_en_nxt", {31'd0, lsu_bus_clk_en_nxt}, {31'd0, (RESET_RATIO == 4'h0)});
`endif
            m_cur = RESET_RATIO;
            m_next = cyc + 1;
            m_mode = MODE_IDLE;
            m_ack_next = 1'b0;
            sb_q.delete();
            prev_valid = 1'b0;
        end else begin
            exp_pulse = (cyc == m_next);
            exp_ack = (m_mode == MODE_SWITCH) || m_ack_next;
            ck("clk_en", {31'd0, lsu_bus_clk_en}, {31'd0, exp_pulse});
            ck("quiesce", {31'd0, lsu_bus_quiesce}, {31'd0, (m_mode != MODE_IDLE)});
            ck("ack", {31'd0, ratio_req_ack}, {31'd0, exp_ack});
            ck("ratio_cur", {28'd0, ratio_cur}, {28'd0, m_cur});
`ifdef RV_BUS_CLKEN_PREDICT_EN
            if (prev_valid) ck("predict", {31'd0, lsu_bus_clk_en}, {31'd0, prev_nxt});
`else
            ck("nxt_tied", {31'd0, lsu_bus_clk_en_nxt}, 32'd0);
`endif
            prev_nxt = lsu_bus_clk_en_nxt;
            prev_valid = 1'b1;

            m_ack_next = 1'b0;
            case (m_mode)
                MODE_SWITCH: begin
                    m_cur = m_pend;
                    m_next = cyc + int'(m_pend) + 1;
                    m_mode = MODE_IDLE;
                end
                MODE_DRAIN: begin
                    if (exp_pulse && bb_empty && sb_empty) begin
                        m_mode = MODE_SWITCH;
                        m_next = cyc + 1;
                    end else if (exp_pulse) begin
                        m_next = cyc + int'(m_cur) + 1;
                    end
                end
                default: begin
                    if (exp_pulse) m_next = cyc + int'(m_cur) + 1;
                    if (ratio_req_vld) begin
                        if (ratio_req != m_cur) begin
                            m_pend = ratio_req;
                            m_mode = MODE_DRAIN;
                            sb_q.push_back(ratio_req);
                        end else if (!exp_ack) begin
                            m_ack_next = 1'b1;
                            sb_q.push_back(ratio_req);
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- scoreboard monitor: each ack retires one request ------
    logic       mon_pending = 1'b0;
    logic [3:0] mon_exp = 4'h0;

    always @(negedge clk) begin
        if (!rst_l) begin
            mon_pending = 1'b0;
        end else begin
            if (mon_pending) begin
                ck("sb_ratio_after_ack", {28'd0, ratio_cur}, {28'd0, mon_exp});
                mon_pending = 1'b0;
            end
            if (ratio_req_ack) begin
                if (sb_q.size() == 0) begin
                    ck("sb_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    mon_pending = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    logic rand_bufs = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bufs) begin
                bb_empty = ($urandom_range(0, 3) != 0);
                sb_empty = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [3:0] r, input int sb_busy, input int bound);
        bit got;
        got = 1'b0;
        ratio_req_vld = 1'b1;
        ratio_req = r;
        if (sb_busy > 0) begin
            sb_empty = 1'b0;
            repeat (sb_busy) @(posedge clk);
            #1;
            sb_empty = 1'b1;
        end
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ratio_req_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) ck("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ratio_req_vld = 1'b0;
    endtask

    initial begin
        rst_l = 1'b0;
        ratio_req_vld = 1'b0;
        ratio_req = 4'h0;
        bb_empty = 1'b1;
        sb_empty = 1'b1;
        idle(3);
        rst_l = 1'b1;
        idle(6);

        do_req(4'd3, 0, 50);
        idle(12);
        do_req(4'd3, 0, 50);
        idle(9);
        do_req(4'd2, 0, 50);
        idle(7);
        do_req(4'd0, 7, 50);
        idle(5);

        bb_empty = 1'b0;
        ratio_req_vld = 1'b1;
        ratio_req = 4'd5;
        idle(3);
        rst_l = 1'b0;
        ratio_req_vld = 1'b0;
        idle(2);
        rst_l = 1'b1;
        bb_empty = 1'b1;
        idle(6);

        rand_bufs = 1'b1;
        for (int k = 0; k < 40; k++) begin
            do_req(4'($urandom_range(0, 15)), 0, 400);
            idle($urandom_range(0, 20));
        end
        rand_bufs = 1'b0;
        idle(1);
        bb_empty = 1'b1;
        sb_empty = 1'b1;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
